// File: rtl/relu_pool_stream.sv
// relu_pool_stream: streaming ReLU followed by non-overlapping POOLxPOOL pooling.
// One pixel position (all channels) per accepted beat in raster order; pooled
// pixels leave on a valid/ready stream through a single output register.
// Optional feature macro: CNN_POOL_AVG_EN adds the pool_mode port (0 = max,
// 1 = average) and widens the accumulators; without it only max pooling exists.
module relu_pool_stream #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32,
  parameter int IMG_W  = 11,
  parameter int IMG_H  = 11,
  parameter int POOL   = 2
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     sync_err
`ifdef CNN_POOL_AVG_EN
  ,
  input  logic                     pool_mode
`endif
);

  localparam int LOG2P = $clog2(POOL);
  localparam int OUT_W = IMG_W / POOL;
  localparam int OUT_H = IMG_H / POOL;
  // Counter widths hold IMG_W / IMG_H themselves so window-limit compares never wrap.
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
`ifdef CNN_POOL_AVG_EN
  // Sum of POOL*POOL non-negative samples needs 2*log2(POOL) extra bits.
  localparam int ACC_W = DATA_W + 2 * LOG2P;
`else
  localparam int ACC_W = DATA_W;
`endif

  logic [CW-1:0]              r_col;
  logic [RW-1:0]              r_row;
  logic                       r_out_valid;
  logic [NUM_CH*DATA_W-1:0]   r_out_data;
  logic                       r_out_last;
  logic                       r_sync_err;
  logic [NUM_CH*ACC_W-1:0]    r_partial [OUT_W];

  logic                       w_accept;
  logic                       w_resync;
  logic [CW-1:0]              w_col;
  logic [RW-1:0]              w_row;
  logic                       w_origin;
  logic                       w_in_win;
  logic                       w_first;
  logic                       w_close;
  logic                       w_last;
  logic [AW-1:0]              w_wx;
  logic [NUM_CH*ACC_W-1:0]    w_old;
  logic [NUM_CH*ACC_W-1:0]    w_comb;
  logic [NUM_CH*DATA_W-1:0]   w_res;

  assign in_ready  = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign sync_err  = r_sync_err;

  assign w_accept = in_valid && in_ready;
  // An in_sof away from (0,0) makes this beat the new (0,0); open windows are
  // abandoned implicitly because the first-pixel rule overwrites their entries.
  assign w_resync = w_accept && in_sof && !((r_col == '0) && (r_row == '0));
  assign w_col    = w_resync ? '0 : r_col;
  assign w_row    = w_resync ? '0 : r_row;
  assign w_origin = (w_col == '0) && (w_row == '0);

  assign w_in_win = (w_col < CW'(OUT_W * POOL)) && (w_row < RW'(OUT_H * POOL));
  assign w_wx     = AW'(w_col >> LOG2P);
  assign w_first  = (w_col[LOG2P-1:0] == '0) && (w_row[LOG2P-1:0] == '0);
  assign w_close  = (w_col[LOG2P-1:0] == {LOG2P{1'b1}}) && (w_row[LOG2P-1:0] == {LOG2P{1'b1}});
  assign w_last   = (w_wx == AW'(OUT_W - 1)) && ((w_row >> LOG2P) == RW'(OUT_H - 1));
  assign w_old    = r_partial[w_wx];

`ifdef CNN_POOL_AVG_EN
  logic r_mode;
  logic w_avg;
  // Mode is latched at the start of each frame; the (0,0) beat itself uses the port.
  assign w_avg = w_origin ? pool_mode : r_mode;

  // Frame-wide pooling mode register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                     r_mode <= 1'b0;
    else if (w_accept && w_origin) r_mode <= pool_mode;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] w_relu;
      logic [ACC_W-1:0]  w_pix;
      logic [ACC_W-1:0]  w_prev;
      logic [ACC_W-1:0]  w_max;

      assign w_relu = in_data[gi*DATA_W + DATA_W - 1] ? '0 : in_data[gi*DATA_W +: DATA_W];
      assign w_pix  = ACC_W'(w_relu);
      assign w_prev = w_old[gi*ACC_W +: ACC_W];
      assign w_max  = ($signed(w_pix) > $signed(w_prev)) ? w_pix : w_prev;
`ifdef CNN_POOL_AVG_EN
      assign w_comb[gi*ACC_W +: ACC_W] = w_first ? w_pix : (w_avg ? (w_pix + w_prev) : w_max);
      // Average divides by POOL*POOL with a truncating shift; max values are
      // below 2^(DATA_W-1) so the same shifted slice is only used in average mode.
      assign w_res[gi*DATA_W +: DATA_W] = w_avg ? w_comb[gi*ACC_W + 2*LOG2P +: DATA_W]
                                                : w_comb[gi*ACC_W +: DATA_W];
`else
      assign w_comb[gi*ACC_W +: ACC_W] = w_first ? w_pix : w_max;
      assign w_res[gi*DATA_W +: DATA_W] = w_comb[gi*ACC_W +: DATA_W];
`endif
    end
  endgenerate

  // Partial-result row; never reset because the first pixel of a window overwrites it.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_win) r_partial[w_wx] <= w_comb;
  end

  // Raster position counters, forced to (0,0) by a resync beat.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (w_row == RW'(IMG_H - 1)) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // Output register: load on window close, otherwise drop valid once taken.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_in_win && w_close) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_last  <= w_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky frame-synchronisation error flag.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)         r_sync_err <= 1'b0;
    else if (w_resync) r_sync_err <= 1'b1;
  end

endmodule
